// File: rtl/conv_window_mac_if.sv
// Bus bundle for conv_window_mac: column stream, flush, coefficient port and result outputs.
// The master modport is the stimulus side, the slave modport is the accumulator.
interface conv_window_mac_if #(
    parameter int DSIZE = 10,
    parameter int LSIZE = 3,
    parameter int CSIZE = 4,
    parameter int OSIZE = 18
);
    logic                     in_valid;
    logic [DSIZE*LSIZE-1:0]   in_col;
    logic                     flush;
    logic                     coef_we;
    logic [7:0]               coef_addr;
    logic [CSIZE-1:0]         coef_data;
    logic                     win_full;
    logic                     out_valid;
    logic [OSIZE-1:0]         out_data;
    logic                     out_sat;
    logic [15:0]              out_count;

    modport master (
        output in_valid, in_col, flush, coef_we, coef_addr, coef_data,
        input  win_full, out_valid, out_data, out_sat, out_count
    );

    modport slave (
        input  in_valid, in_col, flush, coef_we, coef_addr, coef_data,
        output win_full, out_valid, out_data, out_sat, out_count
    );
endinterface

// File: rtl/conv_window_mac.sv
// LSIZE x LSIZE sliding-window multiply-accumulate with a 2-stage product/sum pipeline and saturation.
// Optional macro CONV_WINDOW_ROUND_SHIFT_EN adds parameter OSHIFT: round-half-up right shift before saturation.
module conv_window_mac #(
    parameter int DSIZE = 10,
    parameter int LSIZE = 3,
    parameter int CSIZE = 4,
    parameter int OSIZE = 18
`ifdef CONV_WINDOW_ROUND_SHIFT_EN
    ,
    parameter int OSHIFT = 2
`endif
) (
    input logic             clk,
    input logic             rst,
    conv_window_mac_if.slave bus
);
    localparam int NTAP  = LSIZE * LSIZE;
    localparam int PSIZE = DSIZE + CSIZE;
    localparam int ASIZE = PSIZE + $clog2(NTAP);
    localparam int WSIZE = (((ASIZE + 1) > OSIZE) ? (ASIZE + 1) : OSIZE) + 1;
    localparam int FW    = $clog2(LSIZE + 1);
    localparam logic [WSIZE-1:0] OMAX = WSIZE'((65'd1 << OSIZE) - 65'd1);
`ifdef CONV_WINDOW_ROUND_SHIFT_EN
    localparam logic [WSIZE-1:0] RND =
        (OSHIFT > 0) ? (WSIZE'(1) << ((OSHIFT > 0) ? (OSHIFT - 1) : 0)) : '0;
`endif

    logic [DSIZE-1:0] m_q    [NTAP];
    logic [CSIZE-1:0] coef_q [NTAP];
    logic [PSIZE-1:0] p_q    [NTAP];
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;
    logic             win_full_q;
    logic             acc_q;
    logic             s1_valid_q;
    logic             out_valid_q;
    logic [OSIZE-1:0] out_data_q;
    logic             out_sat_q;
    logic [15:0]      out_count_q;

    logic [ASIZE-1:0] sum_d;
    logic [WSIZE-1:0] scaled_d;
    logic [OSIZE-1:0] out_data_d;
    logic             out_sat_d;

    assign bus.win_full  = win_full_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_count = out_count_q;

    // Fill counter advances on each accepted column and sticks at LSIZE.
    always_comb begin
        fill_d = fill_q;
        if (bus.in_valid && (fill_q != FW'(LSIZE))) begin
            fill_d = fill_q + FW'(1);
        end else begin
            fill_d = fill_q;
        end
    end

    // Stage-2 combinational sum, optional rounding shift and clamp to the output width.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NTAP; k++) begin
            sum_d = sum_d + ASIZE'(p_q[k]);
        end
`ifdef CONV_WINDOW_ROUND_SHIFT_EN
        scaled_d = (WSIZE'(sum_d) + RND) >> OSHIFT;
`else
        scaled_d = WSIZE'(sum_d);
`endif
        if (scaled_d > OMAX) begin
            out_data_d = OSIZE'(OMAX);
            out_sat_d  = 1'b1;
        end else begin
            out_data_d = OSIZE'(scaled_d);
            out_sat_d  = 1'b0;
        end
    end

    // Window, coefficients, product stage, result stage and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NTAP; k++) begin
                m_q[k]    <= '0;
                p_q[k]    <= '0;
                coef_q[k] <= CSIZE'(LSIZE + 1 - (k / LSIZE));
            end
            fill_q      <= '0;
            win_full_q  <= 1'b0;
            acc_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_count_q <= 16'd0;
        end else begin
            // Products sample the coefficient value held before this edge's write.
            for (int k = 0; k < NTAP; k++) begin
                p_q[k] <= PSIZE'(m_q[k]) * PSIZE'(coef_q[k]);
                if (bus.coef_we && (bus.coef_addr == 8'(k))) begin
                    coef_q[k] <= bus.coef_data;
                end
            end
            if (bus.flush) begin
                for (int k = 0; k < NTAP; k++) begin
                    m_q[k] <= '0;
                end
                fill_q      <= '0;
                win_full_q  <= 1'b0;
                acc_q       <= 1'b0;
                s1_valid_q  <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (bus.in_valid) begin
                    for (int i = 0; i < LSIZE; i++) begin
                        m_q[i] <= bus.in_col[DSIZE*i +: DSIZE];
                    end
                    for (int k = LSIZE; k < NTAP; k++) begin
                        m_q[k] <= m_q[k-LSIZE];
                    end
                end
                fill_q      <= fill_d;
                win_full_q  <= (fill_d == FW'(LSIZE));
                acc_q       <= bus.in_valid && (fill_d == FW'(LSIZE));
                s1_valid_q  <= acc_q;
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q  <= out_data_d;
                    out_sat_q   <= out_sat_d;
                    out_count_q <= out_count_q + 16'd1;
                end
            end
        end
    end
endmodule
